// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - command/status bundle for the BCD countdown timer
interface countdown_timer_if;
    logic        i_load;
    logic [23:0] i_bcd_preset;
    logic        i_start;
    logic        i_pause;
    logic [23:0] o_bcd_time;
    logic        o_running;
    logic        o_done;
    logic        o_expired;
    logic        o_preset_err;

    modport master (
        output i_load, i_bcd_preset, i_start, i_pause,
        input  o_bcd_time, o_running, o_done, o_expired, o_preset_err
    );

    modport slave (
        input  i_load, i_bcd_preset, i_start, i_pause,
        output o_bcd_time, o_running, o_done, o_expired, o_preset_err
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - m:ss.mmm BCD countdown timer with ms prescaler
module countdown_timer #(
    parameter int CLK_DIV = 1000
) (
    input logic          i_clk,
    input logic          i_rst,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    state_t      state;
    logic [15:0] presc;
    logic [23:0] time_q;
    logic [23:0] time_dec;
    logic        running_q;
    logic        done_q;
    logic        expired_q;
    logic        err_q;
    logic        preset_valid;
    logic        tick;
    logic        dec_zero;

    assign bus.o_bcd_time   = time_q;
    assign bus.o_running    = running_q;
    assign bus.o_done       = done_q;
    assign bus.o_expired    = expired_q;
    assign bus.o_preset_err = err_q;

    assign preset_valid = (bus.i_bcd_preset[23:20] <= 4'd9) && (bus.i_bcd_preset[19:16] <= 4'd5) &&
                          (bus.i_bcd_preset[15:12] <= 4'd9) && (bus.i_bcd_preset[11:8]  <= 4'd9) &&
                          (bus.i_bcd_preset[7:4]   <= 4'd9) && (bus.i_bcd_preset[3:0]   <= 4'd9);
    assign tick     = (presc == LAST);
    assign dec_zero = (time_dec == 24'd0);

    // Ripple a 1 ms borrow up through the digits; sec tens wraps to 5, minutes saturate.
    always_comb begin
        logic       borrow;
        logic [3:0] d;
        time_dec = time_q;
        borrow   = 1'b1;
        d        = 4'd0;
        for (int i = 0; i < 5; i++) begin
            d = time_q[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    time_dec[i*4 +: 4] = (i == 4) ? 4'd5 : 4'd9;
                end else begin
                    time_dec[i*4 +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        if (borrow && (time_q[23:20] != 4'd0)) begin
            time_dec[23:20] = time_q[23:20] - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            presc     <= 16'd0;
            time_q    <= 24'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.i_load) begin
                if (preset_valid) begin
                    time_q    <= bus.i_bcd_preset;
                    presc     <= 16'd0;
                    state     <= IDLE;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.i_pause && bus.i_start) begin
                            if (time_q != 24'd0) begin
                                state     <= RUN;
                                presc     <= 16'd0;
                                running_q <= 1'b1;
                            end else begin
                                state     <= EXPIRED;
                                done_q    <= 1'b1;
                                expired_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // The zeroing tick outranks a simultaneous pause.
                        if (tick && dec_zero) begin
                            time_q    <= 24'd0;
                            presc     <= 16'd0;
                            state     <= EXPIRED;
                            done_q    <= 1'b1;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                        end else if (bus.i_pause) begin
                            state     <= PAUSED;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            time_q <= time_dec;
                            presc  <= 16'd0;
                        end else begin
                            presc <= presc + 16'd1;
                        end
                    end
                    PAUSED: begin
                        if (!bus.i_pause && bus.i_start) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
